// File: rtl/instr_fetch_memory.sv
// Instruction fetch memory: loader-written word array with a fully pipelined read port.
// Latency: LATENCY cycles from accept to VALID; one accept per cycle, results in order.
// Backpressure: RDY drops while the loader writes (loader priority) or, when built with
//               IMEM_STALL_EN, while STALL is high (whole pipeline and outputs freeze).
//
// Optional feature macro: IMEM_STALL_EN (adds the STALL input).
//
// Ports:
//   CLK      single clock, rising-edge
//   RST      asynchronous active-high reset (clears pipeline and outputs, not memory)
//   REQ/ADDR fetch request and word address, accepted when REQ && RDY
//   RDY      request can be accepted this cycle
//   DO/ERR   fetched word / out-of-range flag, qualified by VALID
//   VALID    one-cycle pulse per accepted fetch (held while stalled)
//   LD_WE/LD_ADDR/LD_DI  loader write port
//   STALL    (IMEM_STALL_EN only) freeze the fetch pipeline
module instr_fetch_memory #(
    parameter int DATAWIDTH = 16,
    parameter int ADDRBUS   = 8,
    parameter int DEPTH     = 256,   // 2 .. 2**ADDRBUS
    parameter int LATENCY   = 2      // 1 .. 4
) (
    input  logic                 CLK,
    input  logic                 RST,
`ifdef IMEM_STALL_EN
    input  logic                 STALL,
`endif
    input  logic                 REQ,
    input  logic [ADDRBUS-1:0]   ADDR,
    output logic                 RDY,
    output logic [DATAWIDTH-1:0] DO,
    output logic                 VALID,
    output logic                 ERR,
    input  logic                 LD_WE,
    input  logic [ADDRBUS-1:0]   LD_ADDR,
    input  logic [DATAWIDTH-1:0] LD_DI
);

    // DEPTH may equal 2**ADDRBUS, so range compares are done one bit wider.
    localparam logic [ADDRBUS:0] DEPTH_W = (ADDRBUS + 1)'(DEPTH);

    logic [DATAWIDTH-1:0] mem [DEPTH];

    logic stall;
`ifdef IMEM_STALL_EN
    assign stall = STALL;
`else
    assign stall = 1'b0;
`endif

    logic accept;
    logic rd_oor;
    logic wr_ok;

    assign RDY    = !LD_WE && !stall;
    assign accept = REQ && RDY;
    assign rd_oor = {1'b0, ADDR} >= DEPTH_W;
    assign wr_ok  = LD_WE && ({1'b0, LD_ADDR} < DEPTH_W);

    // Memory contents survive reset; writes are only blocked while RST is high.
    always_ff @(posedge CLK) begin
        if (!RST && wr_ok) begin
            mem[LD_ADDR] <= LD_DI;
        end
    end

    // Pipeline stage k holds a fetch accepted k edges ago; the last stage drives the outputs.
    logic                 st_vld [LATENCY];
    logic [DATAWIDTH-1:0] st_dat [LATENCY];
    logic                 st_err [LATENCY];

    logic                 nx_vld [LATENCY];
    logic [DATAWIDTH-1:0] nx_dat [LATENCY];
    logic                 nx_err [LATENCY];

    always_comb begin
        // Stage 0 captures the array word at the accept edge, so a write on that same
        // edge is not visible to this fetch; out-of-range fetches return zero.
        nx_vld[0] = accept;
        nx_err[0] = rd_oor;
        nx_dat[0] = rd_oor ? '0 : mem[ADDR];
        for (int k = 1; k < LATENCY; k++) begin
            nx_vld[k] = st_vld[k-1];
            nx_err[k] = st_err[k-1];
            nx_dat[k] = st_dat[k-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < LATENCY; k++) begin
                st_vld[k] <= 1'b0;
                st_dat[k] <= '0;
                st_err[k] <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = 0; k < LATENCY - 1; k++) begin
                st_vld[k] <= nx_vld[k];
                st_dat[k] <= nx_dat[k];
                st_err[k] <= nx_err[k];
            end
            // Output stage: DO keeps the last delivered word between results,
            // ERR is only meaningful alongside VALID.
            st_vld[LATENCY-1] <= nx_vld[LATENCY-1];
            if (nx_vld[LATENCY-1]) begin
                st_dat[LATENCY-1] <= nx_dat[LATENCY-1];
                st_err[LATENCY-1] <= nx_err[LATENCY-1];
            end else begin
                st_err[LATENCY-1] <= 1'b0;
            end
        end
    end

    assign VALID = st_vld[LATENCY-1];
    assign DO    = st_dat[LATENCY-1];
    assign ERR   = st_err[LATENCY-1];

endmodule
